// File: rtl/tl45_execute_if.sv
// Execute-stage bus: operand/decode inputs, memory-stage buffer, redirect and forwarding outputs.
// The slave modport is the execute stage; the master modport is its surroundings.
interface tl45_execute_if;
    logic        i_pipe_stall;
    logic        o_pipe_stall;
    logic        i_pipe_flush;
    logic        o_pipe_flush;
    logic [31:0] i_pc;
    logic [3:0]  i_opcode;
    logic [1:0]  i_cond;
    logic [3:0]  i_dr;
    logic [31:0] i_sr1_val;
    logic [31:0] i_sr2_val;
    logic [31:0] i_imm;
    logic [31:0] o_buf_pc;
    logic [31:0] o_buf_sr1_val;
    logic [31:0] o_buf_sr2_val;
    logic [31:0] o_buf_target_address;
    logic [3:0]  o_buf_opcode;
    logic [3:0]  o_buf_dr;
    logic        o_branch_valid;
    logic [31:0] o_branch_target;
    logic        o_halted;
    logic [3:0]  o_fwd_dr;
    logic [31:0] o_fwd_val;

    modport slave (
        input  i_pipe_stall, i_pipe_flush, i_pc, i_opcode, i_cond, i_dr,
        input  i_sr1_val, i_sr2_val, i_imm,
        output o_pipe_stall, o_pipe_flush, o_buf_pc, o_buf_sr1_val, o_buf_sr2_val,
        output o_buf_target_address, o_buf_opcode, o_buf_dr, o_branch_valid,
        output o_branch_target, o_halted, o_fwd_dr, o_fwd_val
    );

    modport master (
        output i_pipe_stall, i_pipe_flush, i_pc, i_opcode, i_cond, i_dr,
        output i_sr1_val, i_sr2_val, i_imm,
        input  o_pipe_stall, o_pipe_flush, o_buf_pc, o_buf_sr1_val, o_buf_sr2_val,
        input  o_buf_target_address, o_buf_opcode, o_buf_dr, o_branch_valid,
        input  o_branch_target, o_halted, o_fwd_dr, o_fwd_val
    );
endinterface

// File: rtl/tl45_execute.sv
// TL45 execute stage: ALU, control-transfer resolution, HALT latch and memory-stage buffer.
// Define TL45_EXEC_FWD_EN to drive o_fwd_dr/o_fwd_val from the buffer; otherwise they are 0.
module tl45_execute (
    input  logic           i_clk,
    input  logic           i_reset,
    tl45_execute_if.slave  io_bus
);
    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpNand = 4'd1,
        OpAddi = 4'd2,
        OpLw   = 4'd3,
        OpSw   = 4'd4,
        OpGoto = 4'd5,
        OpJalr = 4'd6,
        OpHalt = 4'd7,
        OpSkp  = 4'd8,
        OpLea  = 4'd9
    } op_e;

    typedef enum logic [1:0] {StRun, StShadow, StHalted} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [31:0] r_buf_pc, r_buf_sr1_val, r_buf_sr2_val, r_buf_target_address;
    logic [3:0]  r_buf_opcode, r_buf_dr;
    logic        r_branch_valid, r_pipe_flush;
    logic [31:0] r_branch_target;

    logic [31:0] w_buf_pc, w_buf_sr1_val, w_buf_sr2_val, w_buf_target_address;
    logic [3:0]  w_buf_opcode, w_buf_dr;
    logic        w_branch_valid, w_pipe_flush;
    logic [31:0] w_branch_target;

    logic        w_cond_true, w_taken, w_is_halt;
    logic [31:0] w_target;
    logic        w_accept, w_squash;

    // Control-transfer resolution for the presented instruction
    always_comb begin
        w_cond_true = 1'b0;
        unique case (io_bus.i_cond)
            2'd0: w_cond_true = (io_bus.i_sr1_val == io_bus.i_sr2_val);
            2'd1: w_cond_true = ($signed(io_bus.i_sr1_val) < $signed(io_bus.i_sr2_val));
            2'd2: w_cond_true = ($signed(io_bus.i_sr1_val) > $signed(io_bus.i_sr2_val));
            2'd3: w_cond_true = (io_bus.i_sr1_val != io_bus.i_sr2_val);
            default: w_cond_true = 1'b0;
        endcase

        w_taken  = 1'b0;
        w_target = 32'd0;
        case (io_bus.i_opcode)
            OpGoto: begin
                w_taken  = 1'b1;
                w_target = io_bus.i_pc + 32'd1 + io_bus.i_imm;
            end
            OpJalr: begin
                w_taken  = 1'b1;
                w_target = io_bus.i_sr1_val;
            end
            OpSkp: begin
                w_taken  = w_cond_true;
                w_target = io_bus.i_pc + 32'd2;
            end
            default: ;
        endcase
        w_is_halt = (io_bus.i_opcode == OpHalt);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= StRun;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (io_bus.i_pipe_flush) begin
            if (r_state != StHalted) w_state_next = StRun;
        end else if (!io_bus.i_pipe_stall) begin
            unique case (r_state)
                StRun: begin
                    if (w_taken)        w_state_next = StShadow;
                    else if (w_is_halt) w_state_next = StHalted;
                end
                StShadow: w_state_next = StRun;
                StHalted: w_state_next = StHalted;
                default:  w_state_next = StRun;
            endcase
        end
    end

    // Buffer next-state: hold on stall, bubble on flush/shadow/halted, compute on accept
    always_comb begin
        w_accept = !io_bus.i_pipe_flush && !io_bus.i_pipe_stall && (r_state == StRun);
        w_squash = io_bus.i_pipe_flush || (!io_bus.i_pipe_stall && (r_state != StRun));

        w_buf_pc             = r_buf_pc;
        w_buf_sr1_val        = r_buf_sr1_val;
        w_buf_sr2_val        = r_buf_sr2_val;
        w_buf_target_address = r_buf_target_address;
        w_buf_opcode         = r_buf_opcode;
        w_buf_dr             = r_buf_dr;
        w_branch_valid       = r_branch_valid;
        w_pipe_flush         = r_pipe_flush;
        w_branch_target      = r_branch_target;

        if (w_squash) begin
            w_buf_pc             = 32'd0;
            w_buf_sr1_val        = 32'd0;
            w_buf_sr2_val        = 32'd0;
            w_buf_target_address = 32'd0;
            w_buf_opcode         = OpAdd;
            w_buf_dr             = 4'd0;
            w_branch_valid       = 1'b0;
            w_pipe_flush         = 1'b0;
        end else if (w_accept) begin
            w_buf_pc             = io_bus.i_pc;
            w_buf_sr1_val        = io_bus.i_sr1_val;
            w_buf_sr2_val        = io_bus.i_sr2_val;
            w_buf_target_address = 32'd0;
            w_buf_opcode         = io_bus.i_opcode;
            w_buf_dr             = io_bus.i_dr;
            case (io_bus.i_opcode)
                OpAdd:  w_buf_sr1_val = io_bus.i_sr1_val + io_bus.i_sr2_val;
                OpNand: w_buf_sr1_val = ~(io_bus.i_sr1_val & io_bus.i_sr2_val);
                OpAddi: w_buf_sr1_val = io_bus.i_sr1_val + io_bus.i_imm;
                OpLea:  w_buf_sr1_val = io_bus.i_pc + 32'd1 + io_bus.i_imm;
                OpJalr: w_buf_sr1_val = io_bus.i_pc + 32'd1;
                OpLw, OpSw: w_buf_target_address = io_bus.i_imm;
                OpGoto, OpSkp, OpHalt: w_buf_dr = 4'd0;
                default: ;
            endcase
            w_branch_valid = w_taken;
            w_pipe_flush   = w_taken;
            if (w_taken) w_branch_target = w_target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf_pc             <= 32'd0;
            r_buf_sr1_val        <= 32'd0;
            r_buf_sr2_val        <= 32'd0;
            r_buf_target_address <= 32'd0;
            r_buf_opcode         <= 4'd0;
            r_buf_dr             <= 4'd0;
            r_branch_valid       <= 1'b0;
            r_pipe_flush         <= 1'b0;
            r_branch_target      <= 32'd0;
        end else begin
            r_buf_pc             <= w_buf_pc;
            r_buf_sr1_val        <= w_buf_sr1_val;
            r_buf_sr2_val        <= w_buf_sr2_val;
            r_buf_target_address <= w_buf_target_address;
            r_buf_opcode         <= w_buf_opcode;
            r_buf_dr             <= w_buf_dr;
            r_branch_valid       <= w_branch_valid;
            r_pipe_flush         <= w_pipe_flush;
            r_branch_target      <= w_branch_target;
        end
    end

    assign io_bus.o_pipe_stall         = io_bus.i_pipe_stall;
    assign io_bus.o_pipe_flush         = r_pipe_flush;
    assign io_bus.o_buf_pc             = r_buf_pc;
    assign io_bus.o_buf_sr1_val        = r_buf_sr1_val;
    assign io_bus.o_buf_sr2_val        = r_buf_sr2_val;
    assign io_bus.o_buf_target_address = r_buf_target_address;
    assign io_bus.o_buf_opcode         = r_buf_opcode;
    assign io_bus.o_buf_dr             = r_buf_dr;
    assign io_bus.o_branch_valid       = r_branch_valid;
    assign io_bus.o_branch_target      = r_branch_target;
    assign io_bus.o_halted             = (r_state == StHalted);

`ifdef TL45_EXEC_FWD_EN
    logic w_fwd_kill;

    // Loads, stores and control ops produce no register result here
    always_comb begin
        w_fwd_kill = (r_buf_opcode == OpLw)   || (r_buf_opcode == OpSw) ||
                     (r_buf_opcode == OpGoto) || (r_buf_opcode == OpSkp) ||
                     (r_buf_opcode == OpHalt);
        io_bus.o_fwd_dr  = w_fwd_kill ? 4'd0  : r_buf_dr;
        io_bus.o_fwd_val = w_fwd_kill ? 32'd0 : r_buf_sr1_val;
    end
`else
    assign io_bus.o_fwd_dr  = 4'd0;
    assign io_bus.o_fwd_val = 32'd0;
`endif

endmodule
